// File: rtl/ydemux1to4_buf_pkg.sv
// Shared definitions for the 1-to-4 buffered stream demultiplexer.
package ydemux1to4_buf_pkg;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slotState_t;

endpackage

// File: rtl/ydemux1to4_buf_slot.sv
// Single-entry output buffer with valid/ready handshake and a saturating
// count of words handed to the consumer.
module ydemux_slot
  import ydemux1to4_buf_pkg::*;
#(
  parameter int unsigned SIZE = 32,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SIZE-1:0] loadData,
  input  logic            outReady,
  output logic [SIZE-1:0] outData,
  output logic            outValid,
  output logic [CNTW-1:0] xferCnt
);

  slotState_t state, stateNext;
  logic       drain;

  assign outValid = (state == SLOT_FULL);
  assign drain    = outValid & outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= stateNext;
  end

  // A drain in the same cycle as a load keeps the slot full.
  always_comb begin
    stateNext = state;
    case (state)
      SLOT_EMPTY: if (load)           stateNext = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) stateNext = SLOT_EMPTY;
    endcase
  end

  // Data is left in place on drain; only a new load overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    outData <= '0;
    else if (load) outData <= loadData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      xferCnt <= '0;
    else if (drain && xferCnt != '1) xferCnt <= xferCnt + 1'b1;
  end

endmodule

// File: rtl/ydemux1to4_buf.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted word into
// one of four independent single-entry output buffers.
module ydemux1to4_buf
  import ydemux1to4_buf_pkg::*;
#(
  parameter int unsigned SIZE = 32,
  parameter int unsigned CNTW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SIZE-1:0]         in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_OUT*SIZE-1:0] out_data,
  output logic [NUM_OUT-1:0]      out_valid,
  input  logic [NUM_OUT-1:0]      out_ready,
  output logic [NUM_OUT*CNTW-1:0] xfer_cnt,
  output logic                    busy
);

  logic               accept;
  logic [NUM_OUT-1:0] loadVec;

  // Only the selected buffer can stall the producer.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign busy     = |out_valid;

  always_comb begin
    loadVec         = '0;
    loadVec[in_sel] = accept;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : slotGen
    ydemux_slot #(
      .SIZE(SIZE),
      .CNTW(CNTW)
    ) slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (loadVec[k]),
      .loadData (in_data),
      .outReady (out_ready[k]),
      .outData  (out_data[k*SIZE +: SIZE]),
      .outValid (out_valid[k]),
      .xferCnt  (xfer_cnt[k*CNTW +: CNTW])
    );
  end

endmodule

// File: tb/tb_ydemux1to4_buf.sv
// Self-checking bench for ydemux1to4_buf: directed scenarios plus random
// traffic, all compared against a per-output buffer model.
module tb_ydemux1to4_buf;

  localparam int SIZE = 32;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SIZE-1:0]   in_data = '0;
  logic [1:0]        in_sel = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4*SIZE-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready = '0;
  logic [4*CNTW-1:0] xfer_cnt;
  logic              busy;

  ydemux1to4_buf #(.SIZE(SIZE), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;

  // Reference: what each output buffer holds and how many words left it.
  bit        mFull[4];
  bit [31:0] mData[4];
  int        mCnt[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < 4; k++) begin
      mFull[k] = 0; mData[k] = '0; mCnt[k] = 0;
    end
  endtask

  task automatic checkAll();
    logic [3:0] expValid;
    bit         expReady;
    for (int k = 0; k < 4; k++) expValid[k] = mFull[k];
    expReady = !mFull[in_sel] || out_ready[in_sel];
    chk("out_valid", 32'(out_valid), 32'(expValid));
    chk("busy", 32'(busy), 32'(expValid != 0));
    chk("in_ready", 32'(in_ready), 32'(expReady));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_data[%0d]", k), out_data[k*SIZE +: SIZE], mData[k]);
      chk($sformatf("xfer_cnt[%0d]", k), 32'(xfer_cnt[k*CNTW +: CNTW]), 32'(mCnt[k]));
    end
  endtask

  // Compare at the falling edge, then advance the model by one clock.
  task automatic step();
    bit accept;
    @(negedge clk);
    checkAll();
    accept = in_valid && (!mFull[in_sel] || out_ready[in_sel]);
    for (int k = 0; k < 4; k++) begin
      if (mFull[k] && out_ready[k]) begin
        mFull[k] = 0;
        if (mCnt[k] < CMAX) mCnt[k]++;
      end
    end
    if (accept) begin
      mFull[in_sel] = 1;
      mData[in_sel] = in_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic midReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    modelClear();
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_cnt"}, 32'(xfer_cnt), 32'h0);
    chk({tag, "_data"}, out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'h0);
    drive(0, 0, 0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] cnt0Before, cnt3Before, word;

  initial begin
    modelClear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset with a buffer full
    drive(1, 2'd0, 32'h1111_2222, 4'h0);
    step();
    drive(0, 0, 0, 4'h0);
    step();
    chk("pre_reset_full", 32'(out_valid), 32'h1);
    midReset("reset1");
    step();

    // Single route to output 2, then drain
    drive(1, 2'd2, 32'hDEAD_BEEF, 4'h0);
    step();
    drive(0, 0, 0, 4'h0);
    chk("route_valid", 32'(out_valid), 32'h4);
    chk("route_data", out_data[2*SIZE +: SIZE], 32'hDEAD_BEEF);
    step();
    drive(0, 0, 0, 4'b0100);
    step();
    chk("route_drained", 32'(out_valid), 32'h0);
    chk("route_cnt", 32'(xfer_cnt[2*CNTW +: CNTW]), 32'd1);
    chk("route_data_held", out_data[2*SIZE +: SIZE], 32'hDEAD_BEEF);
    drive(0, 0, 0, 4'h0);
    step();

    // Backpressure on output 1
    drive(1, 2'd1, 32'hB0B0_0001, 4'h0);
    step();
    drive(1, 2'd1, 32'hB0B0_0002, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 32'(in_ready), 32'h0);
      step();
    end
    chk("bp_held", out_data[1*SIZE +: SIZE], 32'hB0B0_0001);
    drive(1, 2'd3, 32'hB0B0_0002, 4'h0);
    #1;
    chk("bp_other_ready", 32'(in_ready), 32'h1);
    step();
    drive(0, 0, 0, 4'h0);
    chk("bp_landed", out_data[3*SIZE +: SIZE], 32'hB0B0_0002);
    chk("bp_valid", 32'(out_valid), 32'b1010);
    step();
    drive(0, 0, 0, 4'hF);
    step();

    // Streaming 8 words through output 0
    cnt0Before = 32'(xfer_cnt[0 +: CNTW]);
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'd0, 32'hA0 + 32'(i), 4'b0001);
      #1;
      chk("stream_ready", 32'(in_ready), 32'h1);
      step();
    end
    drive(0, 0, 0, 4'b0001);
    step();
    chk("stream_cnt", 32'(xfer_cnt[0 +: CNTW]), cnt0Before + 32'd8);
    drive(0, 0, 0, 4'h0);
    step();

    // Concurrent drain of 0 and 3 with a reload of 0
    drive(1, 2'd0, 32'hC000_0000, 4'h0);
    step();
    drive(1, 2'd3, 32'hC000_0003, 4'h0);
    step();
    cnt0Before = 32'(xfer_cnt[0 +: CNTW]);
    cnt3Before = 32'(xfer_cnt[3*CNTW +: CNTW]);
    drive(1, 2'd0, 32'hC0DE_0000, 4'b1001);
    step();
    drive(0, 0, 0, 4'h0);
    chk("conc_valid", 32'(out_valid), 32'b0001);
    chk("conc_data", out_data[0 +: SIZE], 32'hC0DE_0000);
    chk("conc_cnt0", 32'(xfer_cnt[0 +: CNTW]), cnt0Before + 32'd1);
    chk("conc_cnt3", 32'(xfer_cnt[3*CNTW +: CNTW]), cnt3Before + 32'd1);
    step();
    drive(0, 0, 0, 4'hF);
    step();

    // Saturation of output 1 counter
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'd1, 32'h5A00 + 32'(i), 4'b0010);
      step();
    end
    drive(0, 0, 0, 4'b0010);
    step();
    chk("sat_cnt", 32'(xfer_cnt[1*CNTW +: CNTW]), 32'(CMAX));
    drive(1, 2'd1, 32'h5AFF, 4'b0010);
    step();
    step();
    chk("sat_hold", 32'(xfer_cnt[1*CNTW +: CNTW]), 32'(CMAX));
    drive(0, 0, 0, 4'hF);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      word = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), word, 4'($urandom));
      step();
    end

    // Reset mid-transfer with buffers holding words
    drive(1, 2'd2, 32'hFEED_0002, 4'h0);
    step();
    drive(1, 2'd1, 32'hFEED_0001, 4'h0);
    step();
    midReset("reset2");
    drive(0, 0, 0, 4'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
